// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-side signal bundle for alu_sequencer.
// slave = sequencer side, master = requester plus combinational ALU.
interface alu_sequencer_if;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] Ra;
  logic [31:0] Rb;
  logic        busy;
  logic        done;
  logic [63:0] Rc;
  logic        div_by_zero;
  logic        illegal_op;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_rc;

  modport slave (
    input  start, opcode, Ra, Rb, alu_rc,
    output busy, done, Rc, div_by_zero, illegal_op, alu_opcode, alu_a, alu_b
  );

  modport master (
    output start, opcode, Ra, Rb, alu_rc,
    input  busy, done, Rc, div_by_zero, illegal_op, alu_opcode, alu_a, alu_b
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences single-cycle ALU ops and 32-step shift-add multiply / restoring
// divide through an external combinational 32-bit ALU.
module alu_sequencer #(
  parameter int unsigned MULDIV_EN = 1
) (
  input  logic          clock,
  input  logic          clear,
  alu_sequencer_if.slave bus
);

  localparam bit MD = (MULDIV_EN != 0);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b01100;
  localparam logic [4:0] OP_MUL = 5'b01101;
  localparam logic [4:0] OP_NOT = 5'b01111;

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  opcode_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [4:0]  count_reg;
  logic        drain_reg;
  // hi/lo during MUL, rem/quo during DIV
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        dz_reg;
  logic        ill_reg;
  logic [63:0] rc_reg;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_NOT);
  endfunction

  logic        start_mul;
  logic        start_div;
  assign start_mul = MD && (bus.opcode == OP_MUL);
  assign start_div = MD && (bus.opcode == OP_DIV) && (bus.Rb != 32'd0);

  // A captured Div only reaches EXEC when its divisor was zero.
  logic        exec_div_zero;
  logic        exec_illegal;
  assign exec_div_zero = MD && (opcode_reg == OP_DIV);
  assign exec_illegal  = !is_alu_op(opcode_reg) && !exec_div_zero;

  logic [31:0] alu_sum;
  logic        unused_alu_hi;
  assign alu_sum       = bus.alu_rc[31:0];
  assign unused_alu_hi = ^bus.alu_rc[63:32];

  // ALU drive is a decode of registered state only.
  logic [4:0]  alu_op_drv;
  logic [31:0] alu_a_drv;
  logic [31:0] alu_b_drv;
  logic [32:0] div_t;
  assign div_t = {hi_reg, lo_reg[31]};

  always_comb begin
    alu_op_drv = OP_ADD;
    alu_a_drv  = 32'd0;
    alu_b_drv  = 32'd0;
    case (state_reg)
      EXEC: begin
        alu_op_drv = opcode_reg;
        alu_a_drv  = a_reg;
        alu_b_drv  = b_reg;
      end
      MUL: begin
        alu_op_drv = OP_ADD;
        alu_a_drv  = hi_reg;
        alu_b_drv  = a_reg;
      end
      DIV: begin
        alu_op_drv = OP_SUB;
        alu_a_drv  = div_t[31:0];
        alu_b_drv  = b_reg;
      end
      default: ;
    endcase
  end

  // Shift-add step; carry recovered from the 32-bit sum's sign bits.
  logic        mul_carry;
  logic [31:0] mul_hi_next;
  logic [31:0] mul_lo_next;

  always_comb begin
    mul_carry = (hi_reg[31] & a_reg[31]) |
                ((hi_reg[31] | a_reg[31]) & ~alu_sum[31]);
    if (lo_reg[0]) begin
      mul_hi_next = {mul_carry, alu_sum[31:1]};
      mul_lo_next = {alu_sum[0], lo_reg[31:1]};
    end else begin
      mul_hi_next = {1'b0, hi_reg[31:1]};
      mul_lo_next = {hi_reg[0], lo_reg[31:1]};
    end
  end

  // Restoring step; ge means the shifted remainder covers the divisor.
  logic        div_ge;
  logic [31:0] div_rem_next;
  logic [31:0] div_quo_next;

  always_comb begin
    div_ge = div_t[32] |
             (div_t[31] & ~b_reg[31]) |
             (~(div_t[31] ^ b_reg[31]) & ~alu_sum[31]);
    div_rem_next = div_ge ? alu_sum : div_t[31:0];
    div_quo_next = {lo_reg[30:0], div_ge};
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg  <= IDLE;
      opcode_reg <= 5'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      count_reg  <= 5'd0;
      drain_reg  <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
      ill_reg    <= 1'b0;
      rc_reg     <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            opcode_reg <= bus.opcode;
            a_reg      <= bus.Ra;
            b_reg      <= bus.Rb;
            busy_reg   <= 1'b1;
            count_reg  <= 5'd0;
            drain_reg  <= 1'b0;
            hi_reg     <= 32'd0;
            if (start_mul) begin
              lo_reg    <= bus.Rb;
              state_reg <= MUL;
            end else if (start_div) begin
              lo_reg    <= bus.Ra;
              state_reg <= DIV;
            end else begin
              state_reg <= EXEC;
            end
          end
        end

        EXEC: begin
          if (exec_illegal) begin
            rc_reg  <= 64'd0;
            ill_reg <= 1'b1;
          end else if (exec_div_zero) begin
            rc_reg <= {a_reg, 32'hFFFF_FFFF};
            dz_reg <= 1'b1;
          end else begin
            rc_reg <= {32'd0, alu_sum};
          end
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end

        MUL: begin
          // One extra cycle after the last step publishes the product.
          if (drain_reg) begin
            rc_reg    <= {hi_reg, lo_reg};
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            hi_reg    <= mul_hi_next;
            lo_reg    <= mul_lo_next;
            count_reg <= count_reg + 5'd1;
            if (count_reg == 5'd31) drain_reg <= 1'b1;
          end
        end

        DIV: begin
          if (drain_reg) begin
            rc_reg    <= {hi_reg, lo_reg};
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            hi_reg    <= div_rem_next;
            lo_reg    <= div_quo_next;
            count_reg <= count_reg + 5'd1;
            if (count_reg == 5'd31) drain_reg <= 1'b1;
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          dz_reg    <= 1'b0;
          ill_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          drain_reg <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.Rc          = rc_reg;
  assign bus.div_by_zero = dz_reg;
  assign bus.illegal_op  = ill_reg;
  assign bus.alu_opcode  = alu_op_drv;
  assign bus.alu_a       = alu_a_drv;
  assign bus.alu_b       = alu_b_drv;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: two sequencers (Mul/Div enabled and disabled) driven by
// random and directed requests, each checked against an arithmetic model.
module tb_alu_sequencer;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SHR = 5'b00100;
  localparam logic [4:0] OP_DIV = 5'b01100;
  localparam logic [4:0] OP_MUL = 5'b01101;
  localparam logic [4:0] OP_NOT = 5'b01111;

  typedef struct {
    int          dut;
    logic [4:0]  op;
    logic [63:0] rc;
    logic        dz;
    logic        ill;
    int          lat;
  } exp_t;

  logic clock;
  logic clear;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  alu_sequencer_if bus0 ();
  alu_sequencer_if bus1 ();

  alu_sequencer #(.MULDIV_EN(1)) u_dut0 (.clock(clock), .clear(clear), .bus(bus0));
  alu_sequencer #(.MULDIV_EN(0)) u_dut1 (.clock(clock), .clear(clear), .bus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment ALU; upper half is junk the sequencer must ignore.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOT:  return ~a;
      default: return a ^ b ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  always_comb bus0.alu_rc = {32'hA5A5_5A5A, alu_fn(bus0.alu_opcode, bus0.alu_a, bus0.alu_b)};
  always_comb bus1.alu_rc = {32'h3C3C_9696, alu_fn(bus1.alu_opcode, bus1.alu_a, bus1.alu_b)};

  // Reference model: plain arithmetic on the request.
  function automatic exp_t model(input int d, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dut = d; e.op = op; e.rc = 64'd0; e.dz = 1'b0; e.ill = 1'b0; e.lat = 2;
    case (op)
      OP_ADD: e.rc = {32'd0, a + b};
      OP_SUB: e.rc = {32'd0, a - b};
      OP_AND: e.rc = {32'd0, a & b};
      OP_OR:  e.rc = {32'd0, a | b};
      OP_NOT: e.rc = {32'd0, ~a};
      OP_MUL: begin
        if (d == 0) begin
          e.rc  = {32'd0, a} * {32'd0, b};
          e.lat = 34;
        end else e.ill = 1'b1;
      end
      OP_DIV: begin
        if (d != 0) e.ill = 1'b1;
        else if (b == 32'd0) begin
          e.rc = {a, 32'hFFFF_FFFF};
          e.dz = 1'b1;
        end else begin
          e.rc  = {a % b, a / b};
          e.lat = 34;
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
    else pass_cnt++;
  endtask

  logic [1:0]  busy_v, done_v, dz_v, ill_v;
  logic [63:0] rc_v [2];
  logic [4:0]  aop_v [2];
  logic [31:0] aa_v [2];
  logic [31:0] ab_v [2];
  assign busy_v = {bus1.busy, bus0.busy};
  assign done_v = {bus1.done, bus0.done};
  assign dz_v   = {bus1.div_by_zero, bus0.div_by_zero};
  assign ill_v  = {bus1.illegal_op, bus0.illegal_op};
  assign rc_v[0] = bus0.Rc;  assign rc_v[1] = bus1.Rc;
  assign aop_v[0] = bus0.alu_opcode; assign aop_v[1] = bus1.alu_opcode;
  assign aa_v[0] = bus0.alu_a; assign aa_v[1] = bus1.alu_a;
  assign ab_v[0] = bus0.alu_b; assign ab_v[1] = bus1.alu_b;

  // Monitor: pops the scoreboard on every done pulse.
  int          cyc [2];
  logic [63:0] last_rc [2];
  logic        busy_prev [2];
  logic        done_prev [2];
  exp_t        got;

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!clear) begin
        cyc[d] = 0; last_rc[d] = 64'd0; busy_prev[d] = 1'b0; done_prev[d] = 1'b0;
      end else begin
        if (busy_v[d]) cyc[d] = busy_prev[d] ? cyc[d] + 1 : 1;
        if (done_v[d]) begin
          if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: dut%0d Rc=%h, required no done pulse", d, rc_v[d]);
          end else begin
            got = sb.pop_front();
            $display("txn dut%0d op=%05b Rc=%h exp=%h dz=%b ill=%b cycles=%0d", d, got.op, rc_v[d], got.rc, dz_v[d], ill_v[d], cyc[d]);
            check("done_dut_id", 64'(d), 64'(got.dut));
            check("result_rc", rc_v[d], got.rc);
            check("div_by_zero", 64'(dz_v[d]), 64'(got.dz));
            check("illegal_op", 64'(ill_v[d]), 64'(got.ill));
            check("done_latency", 64'(cyc[d]), 64'(got.lat));
            check("busy_at_done", 64'(busy_v[d]), 64'd1);
            last_rc[d] = got.rc;
          end
        end else begin
          check("rc_hold", rc_v[d], last_rc[d]);
          check("flags_idle", {62'd0, dz_v[d], ill_v[d]}, 64'd0);
          if (!busy_v[d]) check("alu_idle_drive", {27'd0, aop_v[d], aa_v[d]} | {32'd0, ab_v[d]}, 64'd0);
        end
        if (done_prev[d] && !done_v[d]) check("busy_after_done", 64'(busy_v[d]), 64'd0);
        busy_prev[d] = busy_v[d];
        done_prev[d] = done_v[d];
      end
    end
  end

  task automatic drive(input int d, input logic s, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (d == 0) begin bus0.start = s; bus0.opcode = op; bus0.Ra = a; bus0.Rb = b; end
    else        begin bus1.start = s; bus1.opcode = op; bus1.Ra = a; bus1.Rb = b; end
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy_v[d]) return;
    end
    total_cnt++;
    $display("FAIL wait_idle_timeout: dut%0d still busy after 200 cycles, required idle", d);
  endtask

  task automatic issue(input int d, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle(d);
    drive(d, 1'b1, op, a, b);
    sb.push_back(model(d, op, a, b));
    @(negedge clock);
    // Scramble operands after acceptance; the result must not change.
    drive(d, 1'b0, 5'($urandom), $urandom, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] edges [4];
    edges[0] = 32'd0; edges[1] = 32'd1; edges[2] = 32'hFFFF_FFFF; edges[3] = 32'h8000_0000;
    case ($urandom_range(0, 7))
      0:       return edges[$urandom_range(0, 3)];
      1:       return 32'($urandom_range(1, 1000));
      default: return $urandom;
    endcase
  endfunction

  task automatic random_txn(input int d);
    logic [4:0]  ops [7];
    logic [4:0]  op;
    logic [31:0] a, b;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
    ops[4] = OP_DIV; ops[5] = OP_MUL; ops[6] = OP_NOT;
    op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 6)] : 5'($urandom);
    a  = rand_operand();
    b  = ($urandom_range(0, 5) == 0) ? 32'd0 : rand_operand();
    issue(d, op, a, b);
  endtask

  initial begin
    clear = 1'b0;
    drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", 64'(busy_v[d]), 64'd0);
      check("reset_done", 64'(done_v[d]), 64'd0);
      check("reset_rc", rc_v[d], 64'd0);
      check("reset_flags", {62'd0, dz_v[d], ill_v[d]}, 64'd0);
    end
    #2 clear = 1'b1;

    issue(0, OP_ADD, 32'd5, 32'd7);
    issue(0, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(0, OP_DIV, 32'd100, 32'd7);
    issue(0, OP_DIV, 32'd9, 32'd0);
    issue(0, OP_SHR, 32'd8, 32'd1);
    drain();

    // Start pulsed mid-multiply must be dropped.
    issue(0, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clock);
    check("busy_mid_mul", 64'(busy_v[0]), 64'd1);
    drive(0, 1'b1, OP_SUB, 32'd50, 32'd3);
    @(negedge clock);
    drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drain();

    // Reset during multiply aborts without a done pulse.
    issue(0, OP_MUL, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (19) @(negedge clock);
    check("busy_before_abort", 64'(busy_v[0]), 64'd1);
    #1 clear = 1'b0;
    #1;
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    check("abort_done", 64'(done_v[0]), 64'd0);
    check("abort_rc", rc_v[0], 64'd0);
    sb.delete();
    repeat (3) @(negedge clock);
    #2 clear = 1'b1;
    issue(0, OP_ADD, 32'd1, 32'd1);
    drain();

    for (int i = 0; i < 50; i++) random_txn(0);
    drain();

    issue(1, OP_MUL, 32'd3, 32'd4);
    issue(1, OP_DIV, 32'd9, 32'd0);
    issue(1, OP_DIV, 32'd50, 32'd5);
    issue(1, OP_SHR, 32'd8, 32'd1);
    issue(1, OP_ADD, 32'd20, 32'd22);
    for (int i = 0; i < 15; i++) random_txn(1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: MULDIV_EN, default 1, 1 = Mul/Div sequenced, 0 = Mul/Div treated as unsupported opcodes.
REQ-002 SHALL have ports, one per line:
 clock  in  1  single clock, all state on rising edge.
 clear  in  1  asynchronous, active-low reset.
 start  in  1  operation request, sampled only when busy=0.
 opcode  in  5  Add 00000, Sub 00001, And 00010, Or 00011, Div 01100, Mul 01101, Not 01111.
 Ra, Rb  in  32  operands, captured on accepted start.
 busy  out  1  high from the cycle after acceptance through the DONE cycle.
 done  out  1  one-cycle pulse; Rc and flags valid.
 Rc  out  64  result; Mul/Div: [63:32]=HI/remainder, [31:0]=LO/quotient; other ops: [63:32]=0.
 div_by_zero  out  1  valid with done.
 illegal_op  out  1  valid with done.
 alu_opcode  out  5  opcode driven to the combinational ALU.
 alu_a, alu_b  out  32  ALU operands.
 alu_rc  in  64  ALU result; only [31:0] used.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, MUL, DIV, DONE.
REQ-004 IDLE: start=1 SHALL capture opcode/Ra/Rb.
 - Transition on the same edge: Add/Sub/And/Or/Not -> EXEC; Mul -> MUL; Div with Rb!=0 -> DIV.
 - Div with Rb=0, and unsupported opcodes -> EXEC.
REQ-005 EXEC SHALL drive alu_opcode=captured opcode, alu_a=Ra, alu_b=Rb, register {32'd0, alu_rc[31:0]} into Rc, then -> DONE.
 - Done SHALL occur 2 cycles after the accepting edge.
REQ-006 Unsupported opcode (incl. Mul/Div when MULDIV_EN=0) SHALL load Rc=0 and set illegal_op=1.
REQ-007 Div by zero SHALL load Rc={Ra, 32'hFFFFFFFF} and set div_by_zero=1.
REQ-008 MUL SHALL run unsigned shift-add for exactly 32 cycles, 5-bit counter 0..31, leaving on count 31.
 - Init: hi=0, lo=Rb, mcand=Ra.
 - Every cycle: alu_opcode=Add, alu_a=hi, alu_b=mcand.
 - Carry c = (a31&b31) | ((a31|b31) & ~sum31).
 - If lo[0]: {hi,lo} <= {c, sum, lo[31:1]}; else {hi,lo} <= {1'b0, hi, lo[31:1]}.
REQ-009 DIV SHALL run unsigned restoring division for exactly 32 cycles.
 - Init: rem=0, quo=Ra.
 - Each cycle: t={rem,quo[31]} (33 bits); alu_opcode=Sub, alu_a=t[31:0], alu_b=Rb.
 - ge = t[32] | (a31&~b31) | (~(a31^b31) & ~diff31).
 - rem <= ge ? diff : t[31:0]; quo <= {quo[30:0], ge}.
REQ-010 MUL/DIV exit SHALL load Rc={hi,lo} or {rem,quo} -> DONE; done 34 cycles after the accepting edge.
REQ-011 DONE SHALL assert done=1 for exactly one cycle, keep busy=1, then -> IDLE.
 - Flags SHALL be valid only while done=1 and SHALL be 0 otherwise.
REQ-012 start while busy=1 SHALL be ignored; no queuing.
 - start in DONE is ignored; back-to-back accepts are spaced ≥1 IDLE cycle.
REQ-013 Rc SHALL hold the last result until the next EXEC/MUL/DIV completion.
 - Operand changes after acceptance SHALL not affect the result.
REQ-014 IDLE SHALL drive alu_opcode=00000, alu_a=0, alu_b=0.

Reset
REQ-015 clear=0 SHALL asynchronously force:
 - State IDLE; busy=0, done=0, Rc=0, div_by_zero=0, illegal_op=0.
 - Counter and hi/lo/rem/quo = 0.
REQ-016 clear mid-operation SHALL abort without a done pulse.
 - First start after release SHALL behave as from power-up.

Verification
REQ-017 Add Ra=5, Rb=7 -> done 2 cycles after accept, Rc=64'h0000_0000_0000_000C, flags 0.
REQ-018 Mul Ra=Rb=32'hFFFF_FFFF -> done at cycle 34, Rc=64'hFFFF_FFFE_0000_0001, busy high cycles 1..34.
REQ-019 Div Ra=100, Rb=7 -> done at 34, Rc={32'd2, 32'd14}; Div Ra=9, Rb=0 -> done at 2, Rc={32'd9, 32'hFFFF_FFFF}, div_by_zero=1.
REQ-020 opcode 00100 (Shr) -> done at 2, Rc=0, illegal_op=1; opcode 01101 with MULDIV_EN=0 -> same.
REQ-021 start Sub pulsed during Mul cycle 10 -> ignored, Mul result unchanged.
REQ-022 clear low at Mul cycle 20 -> busy=0, Rc=0 immediately; no done; next Add 1+1 -> Rc=2.
